// File: rtl/arm_pkg.sv
// Shared types for the iterative multiply unit: operation codes and FSM states.
package arm_pkg;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MLA   = 2'b01,
    UMULL = 2'b10,
    SMULL = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/arm_negate.sv
// Conditional two's-complement: result = negate ? -value : value.
module arm_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             negate,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/arm_mul_unit.sv
// Iterative shift-add multiplier: MUL, MLA, UMULL, SMULL, one multiplier bit per RUN cycle.
module arm_mul_unit
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  mul_state_t       state, state_next;
  mul_op_t          op_r;
  mul_op_t          op_in;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_step;
  logic [PW-1:0]    full;
  logic             sign_r;
  logic [CW-1:0]    count;
  logic             accept;
  logic             signed_in;
  logic             last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] lo_final, hi_final;
  logic             n_final, z_final;

  assign op_in     = mul_op_t'(op);
  assign signed_in = (op_in == SMULL);
  assign accept    = start && (state == IDLE || state == DONE);
  assign last      = (state == RUN) && (count == CW'(1));
  assign prod_step = mplier[0] ? prod + mcand : prod;

  arm_negate #(.WIDTH(WIDTH)) u_mag_a (
    .negate (signed_in & a[WIDTH-1]),
    .value  (a),
    .result (mag_a)
  );

  arm_negate #(.WIDTH(WIDTH)) u_mag_b (
    .negate (signed_in & b[WIDTH-1]),
    .value  (b),
    .result (mag_b)
  );

  // Sign fix and MLA addend are folded into the final RUN step so results land with DONE.
  arm_negate #(.WIDTH(PW)) u_sign (
    .negate (sign_r),
    .value  (prod_step),
    .result (full)
  );

  always_comb begin
    lo_final = full[WIDTH-1:0] + ((op_r == MLA) ? acc_r : '0);
    hi_final = '0;
    n_final  = lo_final[WIDTH-1];
    z_final  = (lo_final == '0);
    if (op_r == UMULL || op_r == SMULL) begin
      hi_final = full[PW-1:WIDTH];
      n_final  = full[PW-1];
      z_final  = (full == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= MUL;
      acc_r     <= '0;
      mplier    <= '0;
      mcand     <= '0;
      prod      <= '0;
      sign_r    <= 1'b0;
      count     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (accept) begin
      op_r   <= op_in;
      acc_r  <= acc;
      mplier <= mag_b;
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      prod   <= '0;
      sign_r <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
      count  <= CW'(WIDTH);
    end else if (state == RUN) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (last) begin
        result_lo <= lo_final;
        result_hi <= hi_final;
        flags     <= {n_final, z_final, 2'b00};
      end
    end
  end

endmodule
